// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: turns one M-stage access into a req/addr_ok/data_ok
// bus transaction, stalls the pipeline until it completes and returns extended load data.
module mem_access_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoregM,
    input  logic        memwriteM,
    input  logic [2:0]  lshbM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        stallM,
    output logic [31:0] readdataM,
    output logic        adelM,
    output logic        adesM,
    output logic        buserrM,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_be,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        req_q, wr_q, load_q, buserr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;

    logic        is_half, is_byte, acc, mis, issue;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        timeout_hit, data_done, timeout_evt;
    logic [31:0] lane, load_ext;

    // Access-type decode of the live M-stage inputs; only used while IDLE.
    always_comb begin
        is_half  = (lshbM == 3'b001) || (lshbM == 3'b010);
        is_byte  = (lshbM == 3'b011) || (lshbM == 3'b100);
        acc      = memtoregM | memwriteM;
        mis      = (~is_half & ~is_byte & (aluoutM[1:0] != 2'b00)) | (is_half & aluoutM[0]);
        issue    = (state_q == S_IDLE) & acc & ~mis;
        if (is_byte) begin
            be_in    = 4'b0001 << aluoutM[1:0];
            wdata_in = {4{writedataM[7:0]}};
        end else if (is_half) begin
            be_in    = aluoutM[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{writedataM[15:0]}};
        end else begin
            be_in    = 4'b1111;
            wdata_in = writedataM;
        end
    end

    always_comb begin
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));
        data_done   = ((state_q == S_ADDR) & data_addr_ok & data_data_ok) |
                      ((state_q == S_WAIT) & data_data_ok);
        timeout_evt = (state_q == S_WAIT) & ~data_data_ok & timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_ADDR;
            S_ADDR: begin
                if (data_addr_ok && data_data_ok) state_d = S_DONE;
                else if (data_addr_ok)            state_d = S_WAIT;
            end
            S_WAIT: if (data_data_ok || timeout_hit) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stallM = issue | (state_q == S_ADDR) | (state_q == S_WAIT);
        adelM  = (state_q == S_IDLE) & memtoregM & mis;
        adesM  = (state_q == S_IDLE) & memwriteM & mis;
    end

    // Word accesses are always aligned, so off_q is zero and lane equals the raw word.
    always_comb begin
        lane = data_rdata >> {off_q, 3'b000};
        case (type_q)
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {16'h0000, lane[15:0]};
            3'b011:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h000000, lane[7:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            load_q   <= 1'b0;
            buserr_q <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            type_q   <= 3'b000;
            off_q    <= 2'b00;
            cnt_q    <= '0;
        end else begin
            req_q    <= (state_d == S_ADDR);
            buserr_q <= timeout_evt;
            if (issue) begin
                addr_q  <= {aluoutM[31:2], 2'b00};
                wr_q    <= memwriteM;
                load_q  <= memtoregM;
                be_q    <= be_in;
                wdata_q <= wdata_in;
                type_q  <= lshbM;
                off_q   <= aluoutM[1:0];
            end
            if ((state_q == S_ADDR) && data_addr_ok)
                cnt_q <= '0;
            else if ((state_q == S_WAIT) && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
            if (data_done && load_q)
                rdata_q <= load_ext;
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_be    = be_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign readdataM  = rdata_q;
    assign buserrM    = buserr_q;
endmodule
